// File: rtl/lru_refill_ctrl.sv
// Miss-side refill controller: latches one miss, fetches the line, writes BEATS fill beats, promotes the victim to MRU.
// Latency from accept to ready is BEATS+2 edges minimum; o_miss_ready is low while a miss is in flight, and memory stalls via ack/rvalid gaps.
module lru_refill_ctrl #(
  parameter int WAYS      = 8,
  parameter int SET_BITS  = 7,
  parameter int BEATS     = 4,
  parameter int BEAT_BITS = 2,
  parameter int DATA_W    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_miss_valid,
  input  logic [SET_BITS-1:0]  i_miss_addr_7,
  output logic                 o_miss_ready,
  input  logic [WAYS-1:0]      i_lru_flag_8,
  output logic                 o_mem_req,
  output logic [SET_BITS-1:0]  o_mem_addr_7,
  input  logic                 i_mem_ack,
  input  logic                 i_mem_rvalid,
  input  logic [DATA_W-1:0]    i_mem_rdata,
  output logic                 o_fill_we,
  output logic [WAYS-1:0]      o_fill_way_8,
  output logic [SET_BITS-1:0]  o_fill_addr_7,
  output logic [BEAT_BITS-1:0] o_fill_beat,
  output logic [DATA_W-1:0]    o_fill_data,
  output logic                 o_lru_upd_en,
  output logic                 o_lru_hit_sig,
  output logic [WAYS-1:0]      o_lru_hit_way_8,
  output logic [SET_BITS-1:0]  o_lru_addr_7,
  output logic                 o_flag_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
  localparam logic [1:0] ST_UPD  = 2'd3;

  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  logic [1:0]           state;
  logic [BEAT_BITS-1:0] beat_cnt;
  logic [WAYS-1:0]      victim_q;
  logic [SET_BITS-1:0]  addr_q;

  // A corrupt flag still yields a usable victim: lowest set bit, or way 0 when empty.
  logic [WAYS-1:0] lowest_bit;
  logic            flag_zero;
  logic            flag_onehot;
  logic [WAYS-1:0] victim_nxt;

  assign lowest_bit  = i_lru_flag_8 & (~i_lru_flag_8 + WAYS'(1));
  assign flag_zero   = (i_lru_flag_8 == '0);
  assign flag_onehot = !flag_zero && ((i_lru_flag_8 & (i_lru_flag_8 - WAYS'(1))) == '0);
  assign victim_nxt  = flag_zero ? WAYS'(1) : lowest_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      beat_cnt        <= '0;
      victim_q        <= '0;
      addr_q          <= '0;
      o_miss_ready    <= 1'b1;
      o_mem_req       <= 1'b0;
      o_mem_addr_7    <= '0;
      o_fill_we       <= 1'b0;
      o_fill_way_8    <= '0;
      o_fill_addr_7   <= '0;
      o_fill_beat     <= '0;
      o_fill_data     <= '0;
      o_lru_upd_en    <= 1'b0;
      o_lru_hit_sig   <= 1'b0;
      o_lru_hit_way_8 <= '0;
      o_lru_addr_7    <= '0;
      o_flag_err      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      o_fill_we       <= 1'b0;
      o_lru_upd_en    <= 1'b0;
      o_lru_hit_sig   <= 1'b0;
      o_lru_hit_way_8 <= '0;
      o_flag_err      <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (i_miss_valid) begin
            state        <= ST_REQ;
            addr_q       <= i_miss_addr_7;
            victim_q     <= victim_nxt;
            o_miss_ready <= 1'b0;
            o_mem_req    <= 1'b1;
            o_mem_addr_7 <= i_miss_addr_7;
            o_flag_err   <= !flag_onehot;
          end
        end

        ST_REQ: begin
          // Beats arriving before the ack has been taken are not part of this line.
          if (i_mem_ack) begin
            state     <= ST_FILL;
            o_mem_req <= 1'b0;
          end
        end

        ST_FILL: begin
          if (i_mem_rvalid) begin
            o_fill_we     <= 1'b1;
            o_fill_beat   <= beat_cnt;
            o_fill_data   <= i_mem_rdata;
            o_fill_way_8  <= victim_q;
            o_fill_addr_7 <= addr_q;
            beat_cnt      <= beat_cnt + BEAT_BITS'(1);
            if (beat_cnt == LAST_BEAT) begin
              state           <= ST_UPD;
              o_lru_upd_en    <= 1'b1;
              o_lru_hit_sig   <= 1'b1;
              o_lru_hit_way_8 <= victim_q;
              o_lru_addr_7    <= addr_q;
            end
          end
        end

        default: begin
          state        <= ST_IDLE;
          o_miss_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lru_refill_ctrl.sv
// Directed bench for lru_refill_ctrl: scoreboard of expected fill writes and LRU updates, checked by a negedge monitor.
module tb_lru_refill_ctrl;

  localparam int WAYS = 8, SET_BITS = 7, BEATS = 4, BEAT_BITS = 2, DATA_W = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_miss_valid;
  logic [SET_BITS-1:0]  i_miss_addr_7;
  logic                 o_miss_ready;
  logic [WAYS-1:0]      i_lru_flag_8;
  logic                 o_mem_req;
  logic [SET_BITS-1:0]  o_mem_addr_7;
  logic                 i_mem_ack;
  logic                 i_mem_rvalid;
  logic [DATA_W-1:0]    i_mem_rdata;
  logic                 o_fill_we;
  logic [WAYS-1:0]      o_fill_way_8;
  logic [SET_BITS-1:0]  o_fill_addr_7;
  logic [BEAT_BITS-1:0] o_fill_beat;
  logic [DATA_W-1:0]    o_fill_data;
  logic                 o_lru_upd_en;
  logic                 o_lru_hit_sig;
  logic [WAYS-1:0]      o_lru_hit_way_8;
  logic [SET_BITS-1:0]  o_lru_addr_7;
  logic                 o_flag_err;

  lru_refill_ctrl #(
    .WAYS(WAYS), .SET_BITS(SET_BITS), .BEATS(BEATS), .BEAT_BITS(BEAT_BITS), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .i_miss_valid(i_miss_valid), .i_miss_addr_7(i_miss_addr_7), .o_miss_ready(o_miss_ready),
    .i_lru_flag_8(i_lru_flag_8),
    .o_mem_req(o_mem_req), .o_mem_addr_7(o_mem_addr_7), .i_mem_ack(i_mem_ack),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_fill_we(o_fill_we), .o_fill_way_8(o_fill_way_8), .o_fill_addr_7(o_fill_addr_7),
    .o_fill_beat(o_fill_beat), .o_fill_data(o_fill_data),
    .o_lru_upd_en(o_lru_upd_en), .o_lru_hit_sig(o_lru_hit_sig),
    .o_lru_hit_way_8(o_lru_hit_way_8), .o_lru_addr_7(o_lru_addr_7),
    .o_flag_err(o_flag_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WAYS-1:0]      way;
    logic [SET_BITS-1:0]  addr;
    logic [BEAT_BITS-1:0] beat;
    logic [DATA_W-1:0]    data;
  } fill_t;

  typedef struct packed {
    logic [WAYS-1:0]     way;
    logic [SET_BITS-1:0] addr;
  } upd_t;

  fill_t fill_q[$];
  upd_t  upd_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    lat++;
  endtask

  // Scoreboard monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_fill_we) begin
        if (fill_q.size() == 0) chk("fill_unexpected", 64'(o_fill_we), 64'd0);
        else begin
          fill_t e;
          e = fill_q.pop_front();
          chk("fill_way",  64'(o_fill_way_8),  64'(e.way));
          chk("fill_addr", 64'(o_fill_addr_7), 64'(e.addr));
          chk("fill_beat", 64'(o_fill_beat),   64'(e.beat));
          chk("fill_data", o_fill_data,        e.data);
        end
      end
      if (o_lru_upd_en) begin
        if (upd_q.size() == 0) chk("upd_unexpected", 64'(o_lru_upd_en), 64'd0);
        else begin
          upd_t u;
          u = upd_q.pop_front();
          chk("upd_way",     64'(o_lru_hit_way_8), 64'(u.way));
          chk("upd_addr",    64'(o_lru_addr_7),    64'(u.addr));
          chk("upd_hit_sig", 64'(o_lru_hit_sig),   64'd1);
        end
      end
    end
  end

  // Runs one complete miss; starts and ends at a negedge with the controller idle.
  task automatic do_miss(input logic [SET_BITS-1:0] a, input logic [WAYS-1:0] fl,
                         input logic [WAYS-1:0] vw, input logic ferr, input int ack_dly,
                         input int gap, input bit rv_req, input bit hold, input logic [63:0] base);
    fill_t f;
    upd_t  u;
    i_miss_valid  = 1'b1;
    i_miss_addr_7 = a;
    i_lru_flag_8  = fl;
    tick();
    lat = 0;
    chk("req_mem_req",  64'(o_mem_req),    64'd1);
    chk("req_mem_addr", 64'(o_mem_addr_7), 64'(a));
    chk("req_ready",    64'(o_miss_ready), 64'd0);
    chk("req_flag_err", 64'(o_flag_err),   64'(ferr));
    i_miss_valid = hold;
    i_lru_flag_8 = 8'hFF;
    for (int i = 0; i < ack_dly; i++) begin
      i_mem_rvalid = rv_req;
      i_mem_rdata  = 64'hDEAD_0000 + 64'(i);
      tick();
      chk("req_held",     64'(o_mem_req),  64'd1);
      chk("flag_err_end", 64'(o_flag_err), 64'd0);
    end
    i_mem_ack    = 1'b1;
    i_mem_rvalid = rv_req;
    i_mem_rdata  = 64'hBAD0;
    tick();
    i_mem_ack    = 1'b0;
    i_mem_rvalid = 1'b0;
    chk("ack_req_drop",   64'(o_mem_req),  64'd0);
    chk("ack_no_fill",    64'(o_fill_we),  64'd0);
    chk("ack_flag_err",   64'(o_flag_err), 64'd0);
    for (int b = 0; b < BEATS; b++) begin
      for (int g = 0; g < gap; g++) tick();
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = base + 64'(b);
      f.way  = vw;
      f.addr = a;
      f.beat = BEAT_BITS'(b);
      f.data = base + 64'(b);
      fill_q.push_back(f);
      if (b == BEATS - 1) begin
        u.way  = vw;
        u.addr = a;
        upd_q.push_back(u);
      end
      tick();
      i_mem_rvalid = 1'b0;
    end
    chk("upd_ready_low", 64'(o_miss_ready), 64'd0);
    chk("upd_strobe",    64'(o_lru_upd_en), 64'd1);
    tick();
    chk("done_ready",   64'(o_miss_ready), 64'd1);
    chk("done_upd_off", 64'(o_lru_upd_en), 64'd0);
    chk("done_hit_way", 64'(o_lru_hit_way_8), 64'd0);
    chk("latency",      64'(lat), 64'(ack_dly + 2 + BEATS * (gap + 1)));
    chk("fill_q_empty", 64'(fill_q.size()), 64'd0);
    chk("upd_q_empty",  64'(upd_q.size()),  64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_miss_valid = 1'b0; i_miss_addr_7 = '0; i_lru_flag_8 = '0;
    i_mem_ack = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready",   64'(o_miss_ready), 64'd1);
    chk("rst_mem_req", 64'(o_mem_req),    64'd0);
    chk("rst_fill_we", 64'(o_fill_we),    64'd0);
    chk("rst_upd_en",  64'(o_lru_upd_en), 64'd0);
    chk("rst_hit_sig", 64'(o_lru_hit_sig), 64'd0);
    chk("rst_flag_err", 64'(o_flag_err),  64'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 64'(o_miss_ready), 64'd1);

    // Nominal back-to-back refill of set 42.
    do_miss(7'd42, 8'b0010_0000, 8'b0010_0000, 1'b0, 0, 0, 1'b0, 1'b0, 64'hA0);
    // Ack delayed 5 cycles with stray rvalid during REQ.
    do_miss(7'd17, 8'b0000_0010, 8'b0000_0010, 1'b0, 5, 0, 1'b1, 1'b0, 64'h1000);
    // Non-one-hot victim flags.
    do_miss(7'd3,  8'b0000_0000, 8'b0000_0001, 1'b1, 0, 0, 1'b0, 1'b0, 64'hB0);
    do_miss(7'd99, 8'b1001_0000, 8'b0001_0000, 1'b1, 1, 0, 1'b0, 1'b0, 64'hC0);
    // Gapped beats with i_miss_valid held high across two misses.
    do_miss(7'd5,  8'b1000_0000, 8'b1000_0000, 1'b0, 0, 2, 1'b0, 1'b1, 64'hD0);
    do_miss(7'd6,  8'b0100_0000, 8'b0100_0000, 1'b0, 0, 2, 1'b0, 1'b0, 64'hE0);

    // Reset in the middle of a refill.
    begin
      fill_t f;
      i_miss_valid = 1'b1; i_miss_addr_7 = 7'd9; i_lru_flag_8 = 8'b0000_0100;
      tick();
      i_miss_valid = 1'b0;
      i_mem_ack = 1'b1;
      tick();
      i_mem_ack = 1'b0;
      for (int b = 0; b < 2; b++) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 64'hF0 + 64'(b);
        f.way = 8'b0000_0100; f.addr = 7'd9; f.beat = BEAT_BITS'(b); f.data = 64'hF0 + 64'(b);
        fill_q.push_back(f);
        tick();
      end
      i_mem_rdata = 64'hF2;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_fill_we", 64'(o_fill_we),    64'd0);
      chk("mid_rst_upd_en",  64'(o_lru_upd_en), 64'd0);
      chk("mid_rst_mem_req", 64'(o_mem_req),    64'd0);
      chk("mid_rst_ready",   64'(o_miss_ready), 64'd1);
      chk("mid_rst_q_empty", 64'(fill_q.size()), 64'd0);
      tick();
      chk("in_rst_fill_we", 64'(o_fill_we), 64'd0);
      rst = 1'b0;
      i_mem_rvalid = 1'b1;
      tick();
      i_mem_rvalid = 1'b0;
      chk("post_rst_fill_we", 64'(o_fill_we),    64'd0);
      chk("post_rst_upd_en",  64'(o_lru_upd_en), 64'd0);
      chk("post_rst_ready",   64'(o_miss_ready), 64'd1);
      chk("post_rst_upd_q",   64'(upd_q.size()), 64'd0);
    end
    do_miss(7'd127, 8'b0000_1000, 8'b0000_1000, 1'b0, 0, 0, 1'b0, 1'b0, 64'h55AA_0000);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
